// File: rtl/mc_counter_pkg.sv
// Shared types for the multi-channel counter: channel mode and FSM state encodings.
package mc_counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'b00,
    SAT     = 2'b01,
    ONESHOT = 2'b10,
    RSVD    = 2'b11
  } cnt_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ch_state_e;

  function automatic cnt_mode_e to_mode(input logic [1:0] m);
    return cnt_mode_e'(m);
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: IDLE/RUN/DONE control with wrap, saturate or one-shot terminal handling.
module counter_channel
  import mc_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ch_state_e        state_q, state_d;
  cnt_mode_e        mode_e;
  logic [WIDTH-1:0] count_d;
  logic             tc_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] load_clamped;
  logic             at_term;

  assign mode_e       = to_mode(mode);
  assign step_val     = up ? (count + ONE) : (count - ONE);
  assign term_val     = up ? limit : '0;
  assign wrap_val     = up ? '0 : limit;
  // >= rather than == so a limit lowered below the running count still terminates.
  assign at_term      = up ? (count >= limit) : (count == '0);
  assign load_clamped = (load_val > limit) ? limit : load_val;
  assign done         = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count   <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      tc      <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count;
    tc_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (load) begin
      count_d = load_clamped;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        DONE: begin
          if (start) begin
            state_d = RUN;
            count_d = wrap_val;
          end
        end
        RUN: begin
          if (en) begin
            if (!at_term) begin
              count_d = step_val;
              // Saturate flags arrival at the end value, not each held cycle.
              tc_d    = (mode_e == SAT) && (step_val == term_val);
            end else begin
              case (mode_e)
                SAT: begin
                  count_d = term_val;
                  tc_d    = (count != term_val);
                end
                ONESHOT: begin
                  tc_d    = 1'b1;
                  state_d = DONE;
                end
                default: begin
                  count_d = wrap_val;
                  tc_d    = 1'b1;
                end
              endcase
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multi_channel_counter.sv
// N_CH independent counter channels sharing one clock; this level only slices and packs buses.
module multi_channel_counter
  import mc_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       up,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       load,
  input  logic [WIDTH*N_CH-1:0] load_val,
  input  logic [WIDTH*N_CH-1:0] limit,
  output logic [WIDTH*N_CH-1:0] count,
  output logic [N_CH-1:0]       tc,
  output logic [N_CH-1:0]       done
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .start    (start[i]),
      .stop     (stop[i]),
      .en       (en[i]),
      .up       (up[i]),
      .mode     (mode[2*i +: 2]),
      .load     (load[i]),
      .load_val (load_val[WIDTH*i +: WIDTH]),
      .limit    (limit[WIDTH*i +: WIDTH]),
      .count    (count[WIDTH*i +: WIDTH]),
      .tc       (tc[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Self-checking bench for multi_channel_counter: vector table on channel 0 plus multi-channel and reset sequences.
module tb_multi_channel_counter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   start, stop, en, up, load;
  logic [2*N-1:0] mode;
  logic [W*N-1:0] load_val, limit;
  logic [W*N-1:0] count;
  logic [N-1:0]   tc, done;

  typedef struct {
    logic [N-1:0]   start, stop, en, up, load;
    logic [2*N-1:0] mode;
    logic [W*N-1:0] lv, lim, cnt;
    logic [N-1:0]   tc, dn;
  } vec_t;

  typedef struct {
    logic [W*N-1:0] cnt;
    logic [N-1:0]   tc, dn;
    string          tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  multi_channel_counter #(.WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en), .up(up),
    .mode(mode), .load(load), .load_val(load_val), .limit(limit),
    .count(count), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t c0(input bit s, input bit sp, input bit e, input bit u,
                              input bit [1:0] m, input bit ld, input bit [7:0] lv,
                              input bit [7:0] lim, input bit [7:0] cnt, input bit t,
                              input bit dn);
    vec_t v;
    v.start = {3'b0, s};   v.stop = {3'b0, sp}; v.en = {3'b0, e};
    v.up    = {3'b0, u};   v.load = {3'b0, ld}; v.mode = {6'b0, m};
    v.lv    = {24'b0, lv}; v.lim = {24'b0, lim}; v.cnt = {24'b0, cnt};
    v.tc    = {3'b0, t};   v.dn = {3'b0, dn};
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    start = v.start; stop = v.stop; en = v.en; up = v.up; load = v.load;
    mode = v.mode; load_val = v.lv; limit = v.lim;
    sb.push_back('{cnt: v.cnt, tc: v.tc, dn: v.dn, tag: tag});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".count"}, count, e.cnt);
      chk({e.tag, ".tc"}, {{(W*N-N){1'b0}}, tc}, {{(W*N-N){1'b0}}, e.tc});
      chk({e.tag, ".done"}, {{(W*N-N){1'b0}}, done}, {{(W*N-N){1'b0}}, e.dn});
    end
  endtask

  function automatic vec_t mv(input logic [N-1:0] s, input logic [N-1:0] sp,
                              input logic [N-1:0] e, input logic [N-1:0] ld,
                              input logic [W*N-1:0] lv, input logic [W*N-1:0] lim,
                              input logic [W*N-1:0] cnt, input logic [N-1:0] t,
                              input logic [N-1:0] dn);
    vec_t v;
    v.start = s; v.stop = sp; v.en = e; v.load = ld;
    v.up = 4'b1101; v.mode = 8'b00_10_01_00;
    v.lv = lv; v.lim = lim; v.cnt = cnt; v.tc = t; v.dn = dn;
    return v;
  endfunction

  initial begin
    // channel 0 vectors: s, sp, e, u, mode, ld, lv, lim -> count, tc, done
    // wrap up, limit 5
    tbl.push_back(c0(1,0,1,1,2'd0,0,0,5, 0,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 1,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 2,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 3,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 4,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 5,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 0,1,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 1,0,0));
    tbl.push_back(c0(0,0,0,1,2'd0,0,0,5, 1,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,5, 2,0,0));
    tbl.push_back(c0(0,1,1,1,2'd0,0,0,5, 2,0,0));
    // saturate down from loaded 3
    tbl.push_back(c0(0,0,0,0,2'd1,1,3,5, 3,0,0));
    tbl.push_back(c0(1,0,1,0,2'd1,0,0,5, 3,0,0));
    tbl.push_back(c0(0,0,1,0,2'd1,0,0,5, 2,0,0));
    tbl.push_back(c0(0,0,1,0,2'd1,0,0,5, 1,0,0));
    tbl.push_back(c0(0,0,1,0,2'd1,0,0,5, 0,1,0));
    tbl.push_back(c0(0,0,1,0,2'd1,0,0,5, 0,0,0));
    tbl.push_back(c0(0,0,1,0,2'd1,0,0,5, 0,0,0));
    tbl.push_back(c0(0,1,0,0,2'd1,0,0,5, 0,0,0));
    // load clamp to limit
    tbl.push_back(c0(0,0,0,0,2'd1,1,9,5, 5,0,0));
    // one-shot up, limit 2, then restart from DONE
    tbl.push_back(c0(0,0,0,1,2'd2,1,0,2, 0,0,0));
    tbl.push_back(c0(1,0,1,1,2'd2,0,0,2, 0,0,0));
    tbl.push_back(c0(0,0,1,1,2'd2,0,0,2, 1,0,0));
    tbl.push_back(c0(0,0,1,1,2'd2,0,0,2, 2,0,0));
    tbl.push_back(c0(0,0,1,1,2'd2,0,0,2, 2,1,1));
    tbl.push_back(c0(0,0,1,1,2'd2,0,0,2, 2,0,1));
    tbl.push_back(c0(1,0,1,1,2'd2,0,0,2, 0,0,0));
    tbl.push_back(c0(0,0,1,1,2'd2,0,0,2, 1,0,0));
    tbl.push_back(c0(0,1,0,1,2'd2,0,0,2, 1,0,0));
    // limit 0 wrap up: continuous tc
    tbl.push_back(c0(0,0,0,1,2'd0,1,0,0, 0,0,0));
    tbl.push_back(c0(1,0,1,1,2'd0,0,0,0, 0,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,0, 0,1,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,0, 0,1,0));
    tbl.push_back(c0(0,1,1,1,2'd0,0,0,0, 0,0,0));
    // load coincident with terminal step, then lowered limit in saturate
    tbl.push_back(c0(0,0,0,1,2'd0,1,3,3, 3,0,0));
    tbl.push_back(c0(1,0,1,1,2'd0,0,0,3, 3,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,1,1,3, 1,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,3, 2,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,3, 3,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,3, 0,1,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,3, 1,0,0));
    tbl.push_back(c0(0,0,1,1,2'd1,0,0,0, 0,1,0));
    tbl.push_back(c0(0,0,1,1,2'd1,0,0,0, 0,0,0));
    tbl.push_back(c0(0,1,0,1,2'd1,0,0,0, 0,0,0));
    // stop beats load at a terminal count; channel then idles
    tbl.push_back(c0(0,0,0,1,2'd0,1,4,4, 4,0,0));
    tbl.push_back(c0(1,0,1,1,2'd0,0,0,4, 4,0,0));
    tbl.push_back(c0(0,1,1,1,2'd0,1,9,4, 4,0,0));
    tbl.push_back(c0(0,0,1,1,2'd0,0,0,4, 4,0,0));
    // wrap down reloads limit
    tbl.push_back(c0(1,0,1,0,2'd0,0,0,4, 4,0,0));
    tbl.push_back(c0(0,0,1,0,2'd0,0,0,4, 3,0,0));
    tbl.push_back(c0(0,0,0,0,2'd0,1,0,4, 0,0,0));
    tbl.push_back(c0(0,0,1,0,2'd0,0,0,4, 4,1,0));
    tbl.push_back(c0(0,1,0,0,2'd0,0,0,4, 4,0,0));

    start = '0; stop = '0; en = '0; up = '0; load = '0;
    mode = '0; load_val = '0; limit = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", count, '0);
    chk("reset.tc", {{(W*N-N){1'b0}}, tc}, '0);
    chk("reset.done", {{(W*N-N){1'b0}}, done}, '0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // independence: ch0 wrap up lim3, ch1 sat down lim5, ch2 one-shot up lim2, ch3 idle
    apply(mv(4'b0000, 4'b0000, 4'b0000, 4'b0111, 32'h00_00_03_00, 32'h07_02_05_03,
             32'h00_00_03_00, 4'b0000, 4'b0000), "ind.load");
    apply(mv(4'b0111, 4'b0000, 4'b1111, 4'b0000, '0, 32'h07_02_05_03,
             32'h00_00_03_00, 4'b0000, 4'b0000), "ind.start");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_03, 32'h00_01_02_01, 4'b0000, 4'b0000), "ind.k1");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_03, 32'h00_02_01_02, 4'b0000, 4'b0000), "ind.k2");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_03, 32'h00_02_00_03, 4'b0110, 4'b0100), "ind.k3");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_03, 32'h00_02_00_00, 4'b0001, 4'b0100), "ind.k4");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_03, 32'h00_02_00_01, 4'b0000, 4'b0100), "ind.k5");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_03, 32'h00_02_00_02, 4'b0000, 4'b0100), "ind.k6");

    // run ch0 to 7 then assert reset between edges
    apply(mv('0, '0, 4'b1111, 4'b0001, 32'h00_00_00_05, 32'h07_02_05_09,
             32'h00_02_00_05, 4'b0000, 4'b0100), "rr.load");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_09, 32'h00_02_00_06, 4'b0000, 4'b0100), "rr.c6");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_09, 32'h00_02_00_07, 4'b0000, 4'b0100), "rr.c7");
    #1 rst = 1'b1;
    #1;
    chk("async.count", count, '0);
    chk("async.tc", {{(W*N-N){1'b0}}, tc}, '0);
    chk("async.done", {{(W*N-N){1'b0}}, done}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_09, '0, 4'b0000, 4'b0000), "post.idle1");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_09, '0, 4'b0000, 4'b0000), "post.idle2");
    apply(mv(4'b0001, '0, 4'b1111, '0, '0, 32'h07_02_05_09, '0, 4'b0000, 4'b0000), "post.start");
    apply(mv('0, '0, 4'b1111, '0, '0, 32'h07_02_05_09, 32'h00_00_00_01, 4'b0000, 4'b0000), "post.step");

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard.drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
